control_edicion: RTL and testbench
==================================

# control_edicion

Edit-mode controller for the clock's time, date and timer settings. It consumes the debounced button levels (Up, Down, Left, Rigth, Ok) and mode switches (F0 = hora, F1 = fecha, F2 = timer) produced by the debounce stage. It snapshots the current values of the selected group, lets the user move a cursor and step field values, then hands the edited group to the RTC write interface through a req/ack handshake.

## Interface
- `NINGUNO`, parameter; reserved, no parameters. Field limits are package constants.
- `Clock`  in  1  system clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-high.
- `Up`, `Down`, `Left`, `Rigth`, `Ok`  in  1 each  debounced button levels.
- `F0`, `F1`, `F2`  in  1 each  debounced switch levels; select hora / fecha / timer.
- `Cur_A`, `Cur_B`, `Cur_C`  in  7 each  current group values, binary: hora/timer = h,m,s; fecha = day,month,year.
- `Wr_Ack`  in  1  write done, from the RTC interface.
- `Campo_A`, `Campo_B`, `Campo_C`  out  7 each  edited values.
- `Cursor`  out  2  selected field, 0..2.
- `Modo`  out  2  0 = none, 1 = hora, 2 = fecha, 3 = timer.
- `Editando`  out  1  high in CARGA and EDITAR.
- `Wr_Req`  out  1  write request.
- `Wr_Sel`  out  2  group being written; equals `Modo`.

## Operation
- **Edge detection.** Each button has a previous-sample register. An action fires on a clock edge that samples the input at 1 while its previous sample was 0. A held button fires once and never repeats.
- **Modes.**
  - Switch decode: `Modo` = 1/2/3 only when exactly one of F0/F1/F2 is high; otherwise 0.
  - The decoded mode is latched when leaving REPOSO.
- **States:**
  - REPOSO: Ok pulse with decoded mode ≠ 0 → CARGA. Ok with mode 0 is ignored.
  - CARGA (1 cycle): `Campo_A/B/C` ← `Cur_A/B/C`; `Cursor` ← 0 → EDITAR.
  - EDITAR: handle cursor and value pulses. Ok pulse → ESCRIBIR. Decoded switch mode ≠ latched mode → REPOSO (abort, no write).
  - ESCRIBIR: `Wr_Req` = 1 until `Wr_Ack` is sampled 1, then → REPOSO. Switch changes are ignored here.
- **Cursor.**
  - Right: +1, wraps 2→0. Left: −1, wraps 0→2.
  - Left and Right pulsing on the same edge: no move.
- **Value steps** act on the field selected by `Cursor`.
  - Up: +1, wraps max→min. Down: −1, wraps min→max.
  - Up and Down pulsing on the same edge: no change.
  - A value pulse and a cursor pulse on the same edge: the value step applies to the old cursor position, and the cursor moves too.
- **Ranges:**
  - hora/timer: A 0..23, B 0..59, C 0..59.
  - fecha: A 1..31 (no month-length check), B 1..12, C 0..99.
- **Outside EDITAR:** value and cursor pulses are ignored. `Wr_Ack` is ignored outside ESCRIBIR.
- **Held values.** `Campo_*` hold their last values after REPOSO is re-entered, whether by write or by abort.

## Timing
- **Reset values:**
  - state REPOSO.
  - `Campo_A/B/C` = 0, `Cursor` = 0, `Modo` = 0.
  - `Editando` = 0, `Wr_Req` = 0, `Wr_Sel` = 0.
  - Previous-sample registers are set to 1, so buttons held through reset do not fire.
- **Latency:**
  - A button rise sampled at edge n updates the outputs after edge n.
  - Ok in REPOSO: CARGA after edge n, EDITAR after edge n+1. `Campo_*` hold the `Cur_*` values sampled at edge n+1.
- **Write handshake.** `Wr_Req` rises after the edge that accepts Ok in EDITAR. It falls after the first edge that samples `Wr_Ack` = 1, with REPOSO entered on that same edge. `Wr_Sel` and `Campo_*` are stable while `Wr_Req` = 1.
- **Mid-operation events:**
  - Reset in any state, including ESCRIBIR: `Wr_Req` drops on the next edge; no handshake is completed.
  - Abort on switch change: takes effect on the same edge that samples the change.
- **`Modo` output:**
  - REPOSO: shows the live decoded switch mode.
  - Other states: shows the latched mode.

## Structure
- Shared package `control_pkg` holds:
  - state encoding: REPOSO, CARGA, EDITAR, ESCRIBIR;
  - mode codes: NINGUNO = 0, HORA = 1, FECHA = 2, TIMER = 3;
  - per-mode field min/max constants.
- Sub-module `detector_flanco` is the one-cycle rising-edge pulse generator with synchronous reset to previous = 1. It is instantiated for Up, Down, Left, Rigth and Ok.
- The FSM, cursor logic and wrap arithmetic live in `control_edicion`. The wrap compare happens before the add, so the 7-bit fields never overflow.

## Test plan
- **Hora write.** F0 = 1, `Cur` = 23,59,58, Ok:
  - one Up on field 0 → 0;
  - Right, Up → 0 (59 wraps);
  - Ok, `Wr_Ack` after 3 cycles → `Wr_Req` high exactly 4 cycles, `Wr_Sel` = 1, `Campo` = 0,0,58.
- **Fecha wrap-down.** F1 = 1, `Cur` = 1,1,0; Down on each field → 31,12,99.
- **Abort.** While in EDITAR, raise F2 as well (two switches on) → REPOSO next edge, `Wr_Req` never asserts, `Editando` = 0.
- **Simultaneous pulses and held buttons.**
  - Up+Down on the same edge → value unchanged.
  - Left+Right → cursor unchanged.
  - Up held 20 cycles → exactly +1.
- **Reset mid-write.** Reset in ESCRIBIR → `Wr_Req` = 0 and all outputs at reset values next edge.
- **Reset with Ok held.** Ok held across reset release → no CARGA entry until Ok is released and pressed again.
- **No valid mode.** No switch on, or two on, then Ok → stays REPOSO, `Modo` = 0.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the edit-mode controller: state and mode encodings
// plus the per-mode field limits.
package control_pkg;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        CARGA    = 2'd1,
        EDITAR   = 2'd2,
        ESCRIBIR = 2'd3
    } estado_t;

    typedef enum logic [1:0] {
        NINGUNO = 2'd0,
        HORA    = 2'd1,
        FECHA   = 2'd2,
        TIMER   = 2'd3
    } modo_t;

    localparam logic [6:0] HT_MIN_A = 7'd0;
    localparam logic [6:0] HT_MAX_A = 7'd23;
    localparam logic [6:0] HT_MIN_B = 7'd0;
    localparam logic [6:0] HT_MAX_B = 7'd59;
    localparam logic [6:0] HT_MIN_C = 7'd0;
    localparam logic [6:0] HT_MAX_C = 7'd59;
    localparam logic [6:0] FE_MIN_A = 7'd1;
    localparam logic [6:0] FE_MAX_A = 7'd31;
    localparam logic [6:0] FE_MIN_B = 7'd1;
    localparam logic [6:0] FE_MAX_B = 7'd12;
    localparam logic [6:0] FE_MIN_C = 7'd0;
    localparam logic [6:0] FE_MAX_C = 7'd99;

    // Exactly one switch high selects a mode; anything else means no mode.
    function automatic modo_t decodifica(input logic f0, input logic f1, input logic f2);
        case ({f2, f1, f0})
            3'b001:  return HORA;
            3'b010:  return FECHA;
            3'b100:  return TIMER;
            default: return NINGUNO;
        endcase
    endfunction

    function automatic logic [6:0] lim_min(input modo_t m, input logic [1:0] idx);
        if (m == FECHA) begin
            case (idx)
                2'd0:    return FE_MIN_A;
                2'd1:    return FE_MIN_B;
                default: return FE_MIN_C;
            endcase
        end
        case (idx)
            2'd0:    return HT_MIN_A;
            2'd1:    return HT_MIN_B;
            default: return HT_MIN_C;
        endcase
    endfunction

    function automatic logic [6:0] lim_max(input modo_t m, input logic [1:0] idx);
        if (m == FECHA) begin
            case (idx)
                2'd0:    return FE_MAX_A;
                2'd1:    return FE_MAX_B;
                default: return FE_MAX_C;
            endcase
        end
        case (idx)
            2'd0:    return HT_MAX_A;
            2'd1:    return HT_MAX_B;
            default: return HT_MAX_C;
        endcase
    endfunction

endpackage

// File: rtl/detector_flanco.sv
// One-cycle rising-edge pulse for a debounced button level. The previous sample
// resets to 1 so a button held through reset does not fire on release of reset.
module detector_flanco (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulso
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b1;
        else     prev <= din;
    end

    assign pulso = din & ~prev;

endmodule

// File: rtl/control_edicion.sv
// Edit-mode controller: snapshots the selected group, lets the user move a
// cursor and step field values, then requests a write to the RTC interface.
module control_edicion
    import control_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Up,
    input  logic       Down,
    input  logic       Left,
    input  logic       Rigth,
    input  logic       Ok,
    input  logic       F0,
    input  logic       F1,
    input  logic       F2,
    input  logic [6:0] Cur_A,
    input  logic [6:0] Cur_B,
    input  logic [6:0] Cur_C,
    input  logic       Wr_Ack,
    output logic [6:0] Campo_A,
    output logic [6:0] Campo_B,
    output logic [6:0] Campo_C,
    output logic [1:0] Cursor,
    output logic [1:0] Modo,
    output logic       Editando,
    output logic       Wr_Req,
    output logic [1:0] Wr_Sel
);

    logic up_p, down_p, left_p, right_p, ok_p;
    estado_t estado;
    modo_t   modo_lat;
    modo_t   modo_vivo;

    detector_flanco u_up    (.clk(Clock), .rst(Reset), .din(Up),    .pulso(up_p));
    detector_flanco u_down  (.clk(Clock), .rst(Reset), .din(Down),  .pulso(down_p));
    detector_flanco u_left  (.clk(Clock), .rst(Reset), .din(Left),  .pulso(left_p));
    detector_flanco u_right (.clk(Clock), .rst(Reset), .din(Rigth), .pulso(right_p));
    detector_flanco u_ok    (.clk(Clock), .rst(Reset), .din(Ok),    .pulso(ok_p));

    assign modo_vivo = decodifica(F0, F1, F2);

    // Limit is compared before stepping, so the 7-bit field never overflows.
    function automatic logic [6:0] paso(input logic [6:0] v, input logic [6:0] vmin,
                                        input logic [6:0] vmax, input logic inc,
                                        input logic dec);
        if (inc && !dec) return (v >= vmax) ? vmin : v + 7'd1;
        if (dec && !inc) return (v <= vmin) ? vmax : v - 7'd1;
        return v;
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado   <= REPOSO;
            modo_lat <= NINGUNO;
            Cursor   <= 2'd0;
            Campo_A  <= 7'd0;
            Campo_B  <= 7'd0;
            Campo_C  <= 7'd0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (ok_p && modo_vivo != NINGUNO) begin
                        modo_lat <= modo_vivo;
                        estado   <= CARGA;
                    end
                end
                CARGA: begin
                    Campo_A <= Cur_A;
                    Campo_B <= Cur_B;
                    Campo_C <= Cur_C;
                    Cursor  <= 2'd0;
                    estado  <= EDITAR;
                end
                EDITAR: begin
                    if (modo_vivo != modo_lat) begin
                        estado <= REPOSO;
                    end else begin
                        if (ok_p) estado <= ESCRIBIR;
                        case (Cursor)
                            2'd0:    Campo_A <= paso(Campo_A, lim_min(modo_lat, 2'd0),
                                                     lim_max(modo_lat, 2'd0), up_p, down_p);
                            2'd1:    Campo_B <= paso(Campo_B, lim_min(modo_lat, 2'd1),
                                                     lim_max(modo_lat, 2'd1), up_p, down_p);
                            default: Campo_C <= paso(Campo_C, lim_min(modo_lat, 2'd2),
                                                     lim_max(modo_lat, 2'd2), up_p, down_p);
                        endcase
                        if (right_p && !left_p)
                            Cursor <= (Cursor == 2'd2) ? 2'd0 : Cursor + 2'd1;
                        else if (left_p && !right_p)
                            Cursor <= (Cursor == 2'd0) ? 2'd2 : Cursor - 2'd1;
                    end
                end
                ESCRIBIR: begin
                    if (Wr_Ack) estado <= REPOSO;
                end
                default: estado <= REPOSO;
            endcase
        end
    end

    assign Editando = (estado == CARGA) || (estado == EDITAR);
    assign Wr_Req   = (estado == ESCRIBIR);
    assign Modo     = (estado == REPOSO) ? modo_vivo : modo_lat;
    assign Wr_Sel   = Modo;

endmodule

// File: tb/tb_control_edicion.sv
// Scoreboard bench for control_edicion: each step queues the hand-derived
// expected output snapshot, then pops and compares it after the clock edge.
module tb_control_edicion;

    logic       Clock = 1'b0;
    logic       Reset, Up, Down, Left, Rigth, Ok, F0, F1, F2, Wr_Ack;
    logic [6:0] Cur_A, Cur_B, Cur_C;
    logic [6:0] Campo_A, Campo_B, Campo_C;
    logic [1:0] Cursor, Modo, Wr_Sel;
    logic       Editando, Wr_Req;

    control_edicion dut (
        .Clock(Clock), .Reset(Reset), .Up(Up), .Down(Down), .Left(Left), .Rigth(Rigth),
        .Ok(Ok), .F0(F0), .F1(F1), .F2(F2), .Cur_A(Cur_A), .Cur_B(Cur_B), .Cur_C(Cur_C),
        .Wr_Ack(Wr_Ack), .Campo_A(Campo_A), .Campo_B(Campo_B), .Campo_C(Campo_C),
        .Cursor(Cursor), .Modo(Modo), .Editando(Editando), .Wr_Req(Wr_Req), .Wr_Sel(Wr_Sel)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } entrada_t;

    entrada_t   cola[$];
    int         checks = 0;
    int         errors = 0;
    int         req_ciclos = 0;

    logic [6:0] ea, eb, ec;
    logic [1:0] ecur, emodo, esel;
    logic       eed, ereq;

    function automatic logic [31:0] empaca(input logic [6:0] a, input logic [6:0] b,
                                           input logic [6:0] c, input logic [1:0] cur,
                                           input logic [1:0] m, input logic ed,
                                           input logic req, input logic [1:0] sel);
        return {3'b000, a, b, c, cur, m, ed, req, sel};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Queue the expected snapshot, clock once, then drain the queue against the DUT.
    task automatic step(input string tag);
        entrada_t e;
        e.tag = tag;
        e.exp = empaca(ea, eb, ec, ecur, emodo, eed, ereq, esel);
        cola.push_back(e);
        @(posedge Clock);
        #1;
        if (Wr_Req) req_ciclos++;
        while (cola.size() > 0) begin
            e = cola.pop_front();
            chk(e.tag, empaca(Campo_A, Campo_B, Campo_C, Cursor, Modo, Editando, Wr_Req, Wr_Sel),
                e.exp);
        end
    endtask

    initial begin
        Reset = 1; Up = 0; Down = 0; Left = 0; Rigth = 0; Ok = 0;
        F0 = 0; F1 = 0; F2 = 0; Wr_Ack = 0; Cur_A = 0; Cur_B = 0; Cur_C = 0;
        ea = 0; eb = 0; ec = 0; ecur = 0; emodo = 0; eed = 0; ereq = 0; esel = 0;
        step("reset0");
        step("reset1");
        Reset = 0;
        step("idle");

        // Hora edit and write
        F0 = 1; Cur_A = 23; Cur_B = 59; Cur_C = 58; emodo = 1; esel = 1;
        step("hora_live");
        Ok = 1; eed = 1; step("hora_carga");
        Ok = 0; ea = 23; eb = 59; ec = 58; step("hora_editar");
        Up = 1; ea = 0; step("hora_up_a");
        Up = 0; step("hora_up_a_rel");
        Rigth = 1; ecur = 1; step("hora_right");
        Rigth = 0; step("hora_right_rel");
        Up = 1; eb = 0; step("hora_up_b");
        Up = 0; step("hora_up_b_rel");
        req_ciclos = 0;
        Ok = 1; ereq = 1; eed = 0; step("hora_wr0");
        Ok = 0; step("hora_wr1");
        step("hora_wr2");
        step("hora_wr3");
        Wr_Ack = 1; ereq = 0; step("hora_ack");
        Wr_Ack = 0; step("hora_held");
        chk("wr_req_ciclos", 32'(req_ciclos), 32'd4);

        // Fecha wrap-down on every field
        F0 = 0; F1 = 1; Cur_A = 1; Cur_B = 1; Cur_C = 0; emodo = 2; esel = 2;
        step("fecha_live");
        Ok = 1; eed = 1; step("fecha_carga");
        Ok = 0; ea = 1; eb = 1; ec = 0; ecur = 0; step("fecha_editar");
        Down = 1; ea = 31; step("fecha_dn_a");
        Down = 0; step("fecha_dn_a_rel");
        Rigth = 1; ecur = 1; step("fecha_r1");
        Rigth = 0; step("fecha_r1_rel");
        Down = 1; eb = 12; step("fecha_dn_b");
        Down = 0; step("fecha_dn_b_rel");
        Rigth = 1; ecur = 2; step("fecha_r2");
        Rigth = 0; step("fecha_r2_rel");
        Down = 1; ec = 99; step("fecha_dn_c");
        Down = 0; step("fecha_dn_c_rel");
        Rigth = 1; ecur = 0; step("cursor_wrap_r");
        Rigth = 0; step("cursor_wrap_r_rel");
        Left = 1; ecur = 2; step("cursor_wrap_l");
        Left = 0; step("cursor_wrap_l_rel");

        // Simultaneous pulses and held buttons
        Up = 1; Down = 1; step("up_down_same");
        Up = 0; Down = 0; step("up_down_rel");
        Left = 1; Rigth = 1; step("left_right_same");
        Left = 0; Rigth = 0; step("left_right_rel");
        Up = 1; ec = 0;
        for (int i = 0; i < 20; i++) step("up_held");
        Up = 0; step("up_held_rel");
        Up = 1; Rigth = 1; ec = 1; ecur = 0; step("value_and_cursor");
        Up = 0; Rigth = 0; step("value_and_cursor_rel");

        // Abort by turning on a second switch
        F2 = 1; eed = 0; emodo = 0; esel = 0; step("abort");
        step("abort_held");

        // No valid mode: two switches, then none
        Ok = 1; step("two_sw_ok");
        Ok = 0; step("two_sw_rel");
        F1 = 0; F2 = 0; Ok = 1; step("no_sw_ok");
        Ok = 0; step("no_sw_rel");

        // Reset while writing; switch change in ESCRIBIR is ignored
        F0 = 1; Cur_A = 5; Cur_B = 6; Cur_C = 7; emodo = 1; esel = 1;
        Ok = 1; eed = 1; step("rst_carga");
        Ok = 0; ea = 5; eb = 6; ec = 7; ecur = 0; step("rst_editar");
        Ok = 1; eed = 0; ereq = 1; step("rst_wr");
        Ok = 0; F0 = 0; step("wr_ignore_sw");
        Reset = 1; ea = 0; eb = 0; ec = 0; ecur = 0; emodo = 0; esel = 0; ereq = 0;
        Ok = 1; step("rst_mid_write");

        // Ok held across reset release
        Reset = 0; F0 = 1; emodo = 1; esel = 1; step("ok_held0");
        step("ok_held1");
        step("ok_held2");
        Ok = 0; step("ok_release");
        Ok = 1; eed = 1; step("ok_repress");
        Ok = 0; ea = 5; eb = 6; ec = 7; step("ok_repress_editar");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
